// File: rtl/serial_frame_receiver.sv
// Bit-serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Produces a parallel word with one-cycle valid, parity-error and framing-error pulses.
module serial_frame_receiver #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_perr;

  logic [WIDTH-1:0] w_shift_next;
  logic             w_parity_mismatch;

  // A one-bit word has nothing to keep, so the shift degenerates to a plain load.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign w_shift_next = serial_in;
    end else begin : g_shift_many
      assign w_shift_next = {serial_in, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_parity_mismatch = (^r_shreg) ^ serial_in;
  assign busy              = (r_state != S_IDLE);

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_perr     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Pulses default low each cycle, so any set below lasts exactly one clock.
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        case (r_state)
          S_IDLE: begin
            if (!serial_in) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
              r_shreg <= '0;
              r_perr  <= 1'b0;
            end
          end
          S_DATA: begin
            r_shreg <= w_shift_next;
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == LAST_BIT) begin
              r_state <= PARITY_EN ? S_PAR : S_STOP;
            end
          end
          S_PAR: begin
            r_perr  <= w_parity_mismatch;
            r_state <= S_STOP;
          end
          S_STOP: begin
            if (!serial_in) begin
              frame_err <= 1'b1;
            end else if (r_perr) begin
              parity_err <= 1'b1;
            end else begin
              data_out   <= r_shreg;
              data_valid <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Bit-serial frame receiver: one line in, parallel word out. It is the receiving end of the team's single-wire serial frame link, whose transmitter shifts words out one bit per strobe.
- Framing: idle-high line, one start bit (0), WIDTH data bits LSB first, optional even-parity bit, one stop bit (1).
- Delivers a one-cycle valid pulse with the assembled word, plus parity and framing error flags, to downstream datapath blocks.

Parameters:
- WIDTH, 8, number of data bits per frame (1..32).
- PARITY_EN, 1, 1 = even-parity bit expected after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_en  input  1  bit strobe; the line is sampled only on cycles where bit_en=1.
- serial_in  input  1  serial line; idle level 1.
- data_out  output  WIDTH  last received word; held until the next frame completes.
- data_valid  output  1  one-cycle pulse when a frame completes without error.
- parity_err  output  1  one-cycle pulse when a frame completes with a parity mismatch.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, bit counter=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0. Deassertion is sampled on the next rising clk edge.
- States: IDLE, DATA, PAR, STOP. All transitions occur only on bit_en=1 cycles. With bit_en=0, state, counter and shift register hold, and all pulse outputs are 0.
- IDLE: sampling serial_in=0 moves to DATA and clears counter and shift register. Sampling 1 stays in IDLE.
- DATA: each sample shifts in at the MSB end (shreg <= {serial_in, shreg[WIDTH-1:1]}), so bit 0 received lands in data_out[0], and the counter increments. After the WIDTH-th sample: go to PAR if PARITY_EN=1, else STOP.
- PAR: sample the parity bit. Set an internal perr = (XOR of shreg) XOR serial_in. Go to STOP.
- STOP, on the sample:
  - serial_in=1 and perr=0: data_out <= shreg, data_valid=1 for exactly one cycle.
  - serial_in=1 and perr=1: parity_err=1 for one cycle; data_out is not updated.
  - serial_in=0: frame_err=1 for one cycle; parity_err is not raised; data_out is not updated.
  - In all three cases, return to IDLE.
- Pulse outputs are registered. They assert in the cycle after the clock edge that samples the stop bit, and deassert on the following clock edge. At most one of the three pulses is high in any cycle.
- Latency: start bit to data_valid is WIDTH+2 bit_en samples (WIDTH+3 with parity). data_valid is visible one clk after the stop-bit sample.
- Back-to-back frames: a start bit sampled on the bit_en immediately after the stop bit is accepted; no idle gap is required.
- Frame-error recovery: a frame_err does not re-arm from the low stop bit. The receiver returns to IDLE and waits for the next sampled 0, so a line stuck low restarts a frame on every subsequent 0 sample.
- Reset mid-frame: the partial frame is discarded, no pulse is emitted, and data_out returns to 0.
- busy is combinational from the state register (state != IDLE).

Test Plan:
- WIDTH=8, PARITY_EN=1. Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1) with bit_en=1 every cycle -> data_valid pulses once, 1 clk after the stop sample; data_out=0xA5; busy falls the same cycle.
- Same frame, but parity bit=1 -> parity_err pulses once; data_valid=0; data_out keeps its previous value (0x00 after reset).
- Send 0x3C with stop bit=0 -> frame_err pulses; no data_valid. Then line idle 1, then a valid 0x01 frame -> data_out=0x01, data_valid pulses.
- bit_en high every 4th cycle, frame 0xFF -> result identical to the full-rate case; state holds across bit_en=0 cycles; pulse width is exactly 1 clk.
- Two back-to-back frames 0x12 then 0x34, no idle gap -> two data_valid pulses, WIDTH+3 samples apart; data_out=0x12 then 0x34.
- Pull rst_n low asynchronously after the 4th data bit of 0x77 -> all outputs 0 immediately. After release, a 0x55 frame -> data_out=0x55, with no stray pulse from the aborted frame.
